// File: rtl/csa_row_mult_pkg.sv
// Shared types and defaults for the carry-save row multiplier.
// Holds the FSM state enum and the default operand width.
package csa_row_mult_pkg;

  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    RESOLVE,
    DONE
  } state_t;

endpackage

// File: rtl/csa_pp_row.sv
// One AND-gated carry-save row: pp = (a & b_bit) ^ inv, then 3:2 compress.
// Ports: a, b_bit, inv (pp bit inversion), s_in, c_in -> s_out, c_out.
module csa_pp_row
  import csa_row_mult_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] a,
  input  logic             b_bit,
  input  logic [WIDTH-1:0] inv,
  input  logic [WIDTH-1:0] s_in,
  input  logic [WIDTH-1:0] c_in,
  output logic [WIDTH-1:0] s_out,
  output logic [WIDTH-1:0] c_out
);

  logic [WIDTH-1:0] pp;

  assign pp    = (a & {WIDTH{b_bit}}) ^ inv;
  assign s_out = pp ^ s_in ^ c_in;
  assign c_out = (pp & s_in) | (pp & c_in) | (s_in & c_in);

endmodule

// File: rtl/csa_row_mult.sv
// Sequential carry-save multiplier: one partial-product row per cycle,
// final carry-propagate add in RESOLVE, valid/ready on both sides.
// Ports: clk, rst_n (sync, active-low), in_valid/in_ready, a, b,
// out_valid/out_ready, p. Macro CSA_ROW_MULT_SIGNED_EN adds tc
// (two's complement operands, Baugh-Wooley).
module csa_row_mult
  import csa_row_mult_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
`ifdef CSA_ROW_MULT_SIGNED_EN
  input  logic               tc,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MSB = WIDTH'(1) << (WIDTH - 1);

  state_t state_q;
  state_t state_d;

  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   s_q;
  logic [WIDTH-1:0]   c_q;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] p_q;
  logic [WIDTH-1:0]   row_s;
  logic [WIDTH-1:0]   row_c;
  logic [WIDTH-1:0]   inv;
  logic [WIDTH-1:0]   corr;

`ifdef CSA_ROW_MULT_SIGNED_EN
  logic tc_q;

  // Baugh-Wooley: invert the sign-column bit of rows 0..W-2 and the
  // non-sign bits of the last row; the missing 2^W + 2^(2W-1) is
  // added into the high half at RESOLVE.
  always_comb begin
    inv  = '0;
    corr = '0;
    if (tc_q) begin
      inv  = (cnt_q == LAST) ? ~MSB : MSB;
      corr = MSB | WIDTH'(1);
    end
  end
`else
  assign inv  = '0;
  assign corr = '0;
`endif

  csa_pp_row #(
    .WIDTH(WIDTH)
  ) u_row (
    .a    (a_q),
    .b_bit(b_q[cnt_q]),
    .inv  (inv),
    .s_in (s_q),
    .c_in (c_q),
    .s_out(row_s),
    .c_out(row_c)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid) state_d = ACCUM;
      ACCUM:   if (cnt_q == LAST) state_d = RESOLVE;
      RESOLVE: state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      c_q     <= '0;
      cnt_q   <= '0;
      p_q     <= '0;
`ifdef CSA_ROW_MULT_SIGNED_EN
      tc_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q   <= a;
            b_q   <= b;
            s_q   <= '0;
            c_q   <= '0;
            cnt_q <= '0;
`ifdef CSA_ROW_MULT_SIGNED_EN
            tc_q  <= tc;
`endif
          end
        end
        ACCUM: begin
          // Sum bit 0 is final; shift the window one weight up.
          s_q   <= {1'b0, row_s[WIDTH-1:1]};
          c_q   <= row_c;
          p_q[WIDTH-1:0] <= {row_s[0], p_q[WIDTH-1:1]};
          cnt_q <= cnt_q + CW'(1);
        end
        RESOLVE: p_q[2*WIDTH-1:WIDTH] <= s_q + c_q + corr;
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign p         = p_q;

endmodule
